ps2_key_tracker: RTL and testbench

//  Parametrised successor to the single-key scan-code FSM. Sits between the ps2_keyboard FIFO
//  and the display/consumer logic. Decodes set-2 make/break/E0/E1 sequences and tracks up to
//  MAX_KEYS held keys plus shift state. Suppresses typematic repeats and counts distinct presses.

---
 rtl/ps2_key_tracker_pkg.sv | 29 ++
 rtl/ps2_scan_ascii.sv | 43 ++++
 rtl/ps2_key_tracker.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// Set-2 scan-code constants and FSM state encoding shared by the key tracker.
package ps2_key_tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_e;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } key_t;

    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] LSHIFT    = 8'h12;
    localparam logic [7:0] RSHIFT    = 8'h59;
    localparam int         PAUSE_LEN = 7;

    // Keyboard status/ack bytes that never start a key sequence.
    function automatic logic is_ignored(input logic [7:0] c);
        return c inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_scan_ascii.sv
// Combinational set-2 scan code to ASCII map: letters, digits (unshifted only), space.
module ps2_scan_ascii (
    input  logic [7:0] scan_code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);

    logic [7:0] letter;
    logic [7:0] digit;

    always_comb begin
        letter = 8'h00;
        digit  = 8'h00;
        case (scan_code_i)
            8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
            8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
            8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
            8'h45: digit = 8'h30;  8'h16: digit = 8'h31;  8'h1E: digit = 8'h32;
            8'h26: digit = 8'h33;  8'h25: digit = 8'h34;  8'h2E: digit = 8'h35;
            8'h36: digit = 8'h36;  8'h3D: digit = 8'h37;  8'h3E: digit = 8'h38;
            8'h46: digit = 8'h39;
            default: ;
        endcase
    end

    // Lower-case codes differ from upper-case only in bit 5.
    always_comb begin
        ascii_o = 8'h00;
        if (letter != 8'h00)
            ascii_o = shift_i ? (letter & 8'hDF) : letter;
        else if (digit != 8'h00)
            ascii_o = shift_i ? 8'h00 : digit;
        else if (scan_code_i == 8'h29)
            ascii_o = 8'h20;
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Set-2 decoder tracking up to MAX_KEYS held keys and shift; events/cur_* lag the accepted byte by one cycle.
// Pops the FIFO with a one-cycle registered strobe, so at most one byte every two cycles.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int MAX_KEYS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_ready,
    output logic                          ps2_nextdata_n,
    output logic                          cur_valid,
    output logic                          cur_ext,
    output logic [7:0]                    cur_code,
    output logic [7:0]                    cur_ascii,
    output logic [$clog2(MAX_KEYS+1)-1:0] held_num,
    output logic [CNT_W-1:0]              press_count,
    output logic                          shift,
    output logic                          evt_valid,
    output logic                          evt_make,
    output logic                          evt_repeat,
    output logic                          evt_ext,
    output logic [7:0]                    evt_code,
    output logic                          table_ovf
);

    localparam int HW = $clog2(MAX_KEYS + 1);

    logic             pop_n_q, byte_vld_q, accept;
    logic [7:0]       byte_q;
    state_e           state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic             lsh_q, lsh_d, rsh_q, rsh_d;
    key_t             key_q [MAX_KEYS];
    key_t             key_d [MAX_KEYS];
    logic [HW-1:0]    num_q, num_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             evt_vld_q, evt_vld_d, evt_make_q, evt_make_d;
    logic             evt_rep_q, evt_rep_d, evt_ext_q, evt_ext_d;
    logic [7:0]       evt_code_q, evt_code_d;
    logic             do_make, do_brk, kext, is_lsh, is_rsh, hit_any;
    logic [MAX_KEYS-1:0] hit;
    key_t             top;
    logic [7:0]       rom_ascii;

    assign accept = ps2_ready && pop_n_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pop_n_q    <= 1'b1;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            lsh_q      <= 1'b0;
            rsh_q      <= 1'b0;
            num_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            evt_vld_q  <= 1'b0;
            evt_make_q <= 1'b0;
            evt_rep_q  <= 1'b0;
            evt_ext_q  <= 1'b0;
            evt_code_q <= '0;
            for (int i = 0; i < MAX_KEYS; i++) key_q[i] <= '0;
        end else begin
            pop_n_q    <= !accept;
            byte_vld_q <= accept;
            if (accept) byte_q <= ps2_data;
            state_q    <= state_d;
            skip_q     <= skip_d;
            lsh_q      <= lsh_d;
            rsh_q      <= rsh_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            evt_vld_q  <= evt_vld_d;
            evt_make_q <= evt_make_d;
            evt_rep_q  <= evt_rep_d;
            evt_ext_q  <= evt_ext_d;
            evt_code_q <= evt_code_d;
            key_q      <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        do_make = 1'b0;
        do_brk  = 1'b0;
        kext    = 1'b0;
        if (byte_vld_q) begin
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == PS2_BRK) state_d = ST_BRK;
                    else if (byte_q == PS2_EXT) state_d = ST_EXT;
                    else if (byte_q == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'(PAUSE_LEN);
                    end else if (!is_ignored(byte_q)) do_make = 1'b1;
                end
                // E0 12 / E0 59 are fake shifts emitted around extended keys.
                ST_EXT: begin
                    if (byte_q == PS2_BRK) state_d = ST_EXT_BRK;
                    else if (byte_q != LSHIFT && byte_q != RSHIFT) begin
                        do_make = 1'b1;
                        kext    = 1'b1;
                    end
                end
                ST_BRK: do_brk = 1'b1;
                ST_EXT_BRK: begin
                    do_brk = 1'b1;
                    kext   = 1'b1;
                end
                ST_SKIP: begin
                    if (skip_q != 3'd1) begin
                        state_d = ST_SKIP;
                        skip_d  = skip_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_KEYS; i++)
            hit[i] = (HW'(i) < num_q) && (key_q[i] == {kext, byte_q});
    end

    assign hit_any = |hit;
    assign is_lsh  = !kext && (byte_q == LSHIFT);
    assign is_rsh  = !kext && (byte_q == RSHIFT);

    always_comb begin : table_upd
        logic seen;
        seen       = 1'b0;
        key_d      = key_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        lsh_d      = lsh_q;
        rsh_d      = rsh_q;
        evt_vld_d  = 1'b0;
        evt_make_d = 1'b0;
        evt_rep_d  = 1'b0;
        evt_ext_d  = 1'b0;
        evt_code_d = '0;
        if (do_make) begin
            if (is_lsh) lsh_d = 1'b1;
            else if (is_rsh) rsh_d = 1'b1;
            else if (hit_any) begin
                evt_vld_d  = 1'b1;
                evt_make_d = 1'b1;
                evt_rep_d  = 1'b1;
                evt_ext_d  = kext;
                evt_code_d = byte_q;
            end else if (num_q != HW'(MAX_KEYS)) begin
                for (int i = 0; i < MAX_KEYS; i++)
                    if (HW'(i) == num_q) key_d[i] = {kext, byte_q};
                num_d      = num_q + 1'b1;
                cnt_d      = cnt_q + 1'b1;
                evt_vld_d  = 1'b1;
                evt_make_d = 1'b1;
                evt_ext_d  = kext;
                evt_code_d = byte_q;
            end else ovf_d = 1'b1;
        end else if (do_brk) begin
            if (is_lsh) lsh_d = 1'b0;
            else if (is_rsh) rsh_d = 1'b0;
            else if (hit_any) begin
                // Entries from the released slot upward slide down by one.
                for (int i = 0; i < MAX_KEYS - 1; i++) begin
                    seen = seen | hit[i];
                    if (seen) key_d[i] = key_q[i+1];
                end
                key_d[MAX_KEYS-1] = '0;
                num_d      = num_q - 1'b1;
                evt_vld_d  = 1'b1;
                evt_ext_d  = kext;
                evt_code_d = byte_q;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < MAX_KEYS; i++)
            if (HW'(i + 1) == num_q) top = key_q[i];
    end

    ps2_scan_ascii u_ascii (
        .scan_code_i (top.code),
        .shift_i     (shift),
        .ascii_o     (rom_ascii)
    );

    assign ps2_nextdata_n = pop_n_q;
    assign cur_valid      = (num_q != '0);
    assign cur_ext        = cur_valid && top.ext;
    assign cur_code       = cur_valid ? top.code : 8'h00;
    assign cur_ascii      = (cur_valid && !top.ext) ? rom_ascii : 8'h00;
    assign held_num       = num_q;
    assign press_count    = cnt_q;
    assign shift          = lsh_q || rsh_q;
    assign evt_valid      = evt_vld_q;
    assign evt_make       = evt_make_q;
    assign evt_repeat     = evt_rep_q;
    assign evt_ext        = evt_ext_q;
    assign evt_code       = evt_code_q;
    assign table_ovf      = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: FIFO model, queue-based reference model checked every cycle, plus literal checks.
module tb_ps2_key_tracker;
    localparam int MK = 4;
    localparam int CW = 2;
    localparam int HW = $clog2(MK + 1);
    typedef logic [7:0] bytes_t [$];

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    ps2_data = 8'h00;
    logic          ps2_ready = 1'b0;
    logic          ps2_nextdata_n, cur_valid, cur_ext, shift, table_ovf;
    logic [7:0]    cur_code, cur_ascii, evt_code;
    logic [HW-1:0] held_num;
    logic [CW-1:0] press_count;
    logic          evt_valid, evt_make, evt_repeat, evt_ext;

    ps2_key_tracker #(.MAX_KEYS(MK), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
        .ps2_nextdata_n(ps2_nextdata_n), .cur_valid(cur_valid), .cur_ext(cur_ext),
        .cur_code(cur_code), .cur_ascii(cur_ascii), .held_num(held_num),
        .press_count(press_count), .shift(shift), .evt_valid(evt_valid),
        .evt_make(evt_make), .evt_repeat(evt_repeat), .evt_ext(evt_ext),
        .evt_code(evt_code), .table_ovf(table_ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic [7:0] LET [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                             8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                             8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Reference model state: held keys newest-last, values are {ext, code}.
    logic [7:0] fifo_q [$];
    logic [8:0] m_held [$];
    int         m_state = 0;  // 0 idle, 1 after E0, 2 after F0, 3 after E0 F0, 4 pause skip
    int         m_skip = 0;
    int         m_cnt = 0;
    bit         m_lsh = 0, m_rsh = 0, m_ovf = 0;
    bit         m_popn = 1, m_pend = 0, m_valid = 0;
    logic [7:0] m_pbyte = 8'h00;
    bit         me_v = 0, me_make = 0, me_rep = 0, me_ext = 0;
    logic [7:0] me_code = 8'h00;

    function automatic logic [7:0] m_ascii();
        logic [8:0] k;
        bit sh;
        sh = m_lsh || m_rsh;
        if (m_held.size() == 0) return 8'h00;
        k = m_held[m_held.size()-1];
        if (k[8]) return 8'h00;
        for (int i = 0; i < 26; i++) if (LET[i] == k[7:0]) return sh ? 8'(65 + i) : 8'(97 + i);
        for (int i = 0; i < 10; i++) if (DIG[i] == k[7:0]) return sh ? 8'h00 : 8'(48 + i);
        if (k[7:0] == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    task automatic model_key(input bit ext, input bit brk, input logic [7:0] c);
        int idx;
        idx = -1;
        if (!ext && (c == 8'h12 || c == 8'h59)) begin
            if (c == 8'h12) m_lsh = !brk; else m_rsh = !brk;
            return;
        end
        for (int i = 0; i < m_held.size(); i++) if (m_held[i] == {ext, c}) idx = i;
        if (!brk) begin
            if (idx >= 0) begin
                me_v = 1; me_make = 1; me_rep = 1; me_ext = ext; me_code = c;
            end else if (m_held.size() < MK) begin
                m_held.push_back({ext, c});
                m_cnt = (m_cnt + 1) % (1 << CW);
                me_v = 1; me_make = 1; me_ext = ext; me_code = c;
            end else m_ovf = 1;
        end else if (idx >= 0) begin
            m_held.delete(idx);
            me_v = 1; me_ext = ext; me_code = c;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_state)
            0: begin
                if (b == 8'hF0) m_state = 2;
                else if (b == 8'hE0) m_state = 1;
                else if (b == 8'hE1) begin m_state = 4; m_skip = 7; end
                else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) model_key(0, 0, b);
            end
            1: begin
                m_state = 0;
                if (b == 8'hF0) m_state = 3;
                else if (b != 8'h12 && b != 8'h59) model_key(1, 0, b);
            end
            2: begin m_state = 0; model_key(0, 1, b); end
            3: begin m_state = 0; model_key(1, 1, b); end
            default: begin m_skip--; if (m_skip == 0) m_state = 0; end
        endcase
    endtask

    task automatic model_step(input logic r, input logic rdy, input logic [7:0] d);
        me_v = 0; me_make = 0; me_rep = 0; me_ext = 0; me_code = 8'h00;
        if (!r) begin
            m_popn = 1; m_pend = 0; m_state = 0; m_skip = 0; m_lsh = 0; m_rsh = 0;
            m_held.delete(); m_cnt = 0; m_ovf = 0; m_valid = 1;
        end else begin
            if (m_pend) model_byte(m_pbyte);
            m_pend = 0;
            if (rdy && m_popn) begin m_pend = 1; m_pbyte = d; m_popn = 0; end
            else m_popn = 1;
        end
    endtask

    // Observed-event and pop-strobe statistics for the literal checks.
    int ev_n = 0, ev_new = 0, ev_rep = 0, ev_brk = 0;
    logic [7:0] ev_last_code = 8'h00;
    logic       ev_last_ext = 1'b0;
    int cyc = 0, last_low = -10, pl_n = 0, pl_bad = 0;

    initial begin : env
        logic c_popn, c_rstn, c_rdy;
        logic [7:0] c_dat;
        forever begin
            @(negedge clk);
            cyc++;
            if (m_valid) begin
                chk("nextdata_n", ps2_nextdata_n, m_popn);
                chk("cur_valid", cur_valid, m_held.size() != 0);
                chk("cur_ext", cur_ext, m_held.size() != 0 ? m_held[m_held.size()-1][8] : 1'b0);
                chk("cur_code", cur_code, m_held.size() != 0 ? m_held[m_held.size()-1][7:0] : 8'h00);
                chk("cur_ascii", cur_ascii, m_ascii());
                chk("held_num", held_num, m_held.size());
                chk("press_count", press_count, m_cnt);
                chk("shift", shift, m_lsh || m_rsh);
                chk("table_ovf", table_ovf, m_ovf);
                chk("evt_valid", evt_valid, me_v);
                if (me_v) begin
                    chk("evt_make", evt_make, me_make);
                    chk("evt_repeat", evt_repeat, me_rep);
                    chk("evt_ext", evt_ext, me_ext);
                    chk("evt_code", evt_code, me_code);
                end
            end
            if (evt_valid) begin
                ev_n++;
                if (evt_make && !evt_repeat) ev_new++;
                if (evt_repeat) ev_rep++;
                if (!evt_make) ev_brk++;
                ev_last_code = evt_code;
                ev_last_ext  = evt_ext;
            end
            if (!ps2_nextdata_n) begin
                pl_n++;
                if (cyc - last_low < 2) pl_bad++;
                last_low = cyc;
            end
            c_popn = ps2_nextdata_n;
            @(posedge clk);
            c_rstn = rstn; c_rdy = ps2_ready; c_dat = ps2_data;
            #1;
            model_step(c_rstn, c_rdy, c_dat);
            if (!c_popn && fifo_q.size() != 0) void'(fifo_q.pop_front());
            ps2_ready = (fifo_q.size() != 0);
            ps2_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    task automatic send(input bytes_t bs);
        int n;
        foreach (bs[i]) fifo_q.push_back(bs[i]);
        n = 0;
        while (fifo_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("fifo_drain", n < 400, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr_stats();
        ev_n = 0; ev_new = 0; ev_rep = 0; ev_brk = 0; pl_n = 0; pl_bad = 0;
    endtask

    initial begin : stim
        // Byte waiting in the FIFO during reset must stay put and be consumed afterwards.
        fifo_q.push_back(8'h1C);
        repeat (4) @(negedge clk);
        chk("rst_nextdata_n", ps2_nextdata_n, 1'b1);
        chk("rst_held_num", held_num, 0);
        chk("rst_press_count", press_count, 0);
        chk("rst_cur_valid", cur_valid, 1'b0);
        chk("rst_table_ovf", table_ovf, 1'b0);
        chk("rst_fifo_untouched", fifo_q.size(), 1);
        rstn = 1'b1;
        send('{});
        chk("a_new_evts", ev_new, 1);
        chk("a_evt_code", ev_last_code, 8'h1C);
        chk("a_press_count", press_count, 1);
        chk("a_ascii", cur_ascii, 8'h61);
        send('{8'hF0, 8'h1C});
        chk("a_brk_evts", ev_brk, 1);
        chk("a_held_empty", held_num, 0);
        chk("a_cur_valid", cur_valid, 1'b0);

        clr_stats();
        send('{8'h12, 8'h1C, 8'h1C, 8'h1C});
        chk("b_shift", shift, 1'b1);
        chk("b_new_evts", ev_new, 1);
        chk("b_rep_evts", ev_rep, 2);
        chk("b_press_count", press_count, 2);
        chk("b_ascii_upper", cur_ascii, 8'h41);
        send('{8'hF0, 8'h1C, 8'hF0, 8'h12});
        chk("b_shift_rel", shift, 1'b0);

        send('{8'h1C, 8'h32});
        chk("c_top_32", cur_code, 8'h32);
        chk("c_held_2", held_num, 2);
        chk("c_count_wrap", press_count, 0);
        send('{8'hF0, 8'h32});
        chk("c_top_back_1C", cur_code, 8'h1C);
        chk("c_held_1", held_num, 1);
        send('{8'hF0, 8'h1C});
        chk("c_held_0", held_num, 0);

        clr_stats();
        send('{8'hFA, 8'hAA, 8'hE0, 8'h75});
        chk("d_one_evt", ev_n, 1);
        chk("d_evt_ext", ev_last_ext, 1'b1);
        chk("d_evt_code", ev_last_code, 8'h75);
        chk("d_ascii_ext", cur_ascii, 8'h00);
        send('{8'hE0, 8'hF0, 8'h75});
        chk("d_ext_released", held_num, 0);

        clr_stats();
        send('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77});
        chk("e_pause_no_evts", ev_n, 0);
        chk("e_pause_held", held_num, 0);
        send('{8'h29});
        chk("e_space_ascii", cur_ascii, 8'h20);
        send('{8'hF0, 8'h29});

        send('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C});
        chk("f_ovf", table_ovf, 1'b1);
        chk("f_held_full", held_num, MK);
        chk("f_top", cur_code, 8'h2D);
        chk("f_count", press_count, 2);
        send('{8'hF0, 8'h15, 8'hF0, 8'h1D, 8'hF0, 8'h24, 8'hF0, 8'h2D, 8'hF0, 8'h2C});
        chk("f_drained", held_num, 0);
        chk("f_ovf_sticky", table_ovf, 1'b1);

        send('{8'h16});
        chk("g_digit", cur_ascii, 8'h31);
        send('{8'h59});
        chk("g_shifted_digit", cur_ascii, 8'h00);
        send('{8'hF0, 8'h59, 8'hF0, 8'h16});

        clr_stats();
        send('{8'h1C, 8'hF0, 8'h1C});
        chk("h_pop_pulses", pl_n, 3);
        chk("h_pop_spacing", pl_bad, 0);
        chk("h_count_wrap", press_count, 0);

        send('{8'hF0});
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        send('{8'h1C});
        chk("i_make_after_rst", held_num, 1);
        chk("i_code", cur_code, 8'h1C);
        chk("i_count", press_count, 1);
        chk("i_ovf_cleared", table_ovf, 1'b0);
        send('{8'hF0, 8'h1C});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
